// File: rtl/adder48_seq_ctrl.sv
`timescale 1ns/1ps
// adder48_seq_ctrl
//
// Performs a W-bit add (W = SLICE_W * NUM_SLICES, 48 by default) by sending
// one SLICE_W-bit slice per cycle through a single shared external adder. The
// slice carry-out is registered and returned as the carry-in of the next slice.
// This trades latency for area compared with NUM_SLICES parallel adders.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. out_valid stays high with a stable payload until
// out_ready is seen.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  operand request handshake
//   in_a, in_b, in_c0  W-bit operands and carry-in, latched at accept
//   out_valid/out_ready result handshake
//   out_s, out_c48     W-bit sum and carry-out of the top slice
//   out_zero           out_s == 0
//   out_ovf            signed overflow of the latched operands
//   busy               controller is not idle
//   slice_a/b/cin      operands driven to the shared adder slice (zero outside RUN)
//   slice_s/cout       combinational result returned by the shared adder slice
//   dbg_state          current FSM state, for observation only
module adder48_seq_ctrl #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 3,
    localparam int W         = SLICE_W * NUM_SLICES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_c0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_s,
    output logic               out_c48,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               busy,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    output logic               slice_cin,
    input  logic [SLICE_W-1:0] slice_s,
    input  logic               slice_cout,
    output logic [1:0]         dbg_state
);

    localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic               r_carry;
    logic [W-1:0]       r_res;
    logic               r_c_out;

    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic               w_slice_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= in_a;
                        r_op_b  <= in_b;
                        r_carry <= in_c0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // One slice per cycle, least significant first; the slice
                    // carry-out becomes the carry-in of the next slice.
                    r_res[r_cnt*SLICE_W +: SLICE_W] <= slice_s;
                    r_carry <= slice_cout;
                    if (r_cnt == LAST_CNT) begin
                        r_c_out <= slice_cout;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE first keeps result handshake and
                    // operand accept in separate cycles.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The shared slice only sees live operands while running, so the adder
    // inputs are quiet (all zero) whenever it is not in use.
    always_comb begin
        w_slice_a   = '0;
        w_slice_b   = '0;
        w_slice_cin = 1'b0;
        if (r_state == ST_RUN) begin
            w_slice_a   = r_op_a[r_cnt*SLICE_W +: SLICE_W];
            w_slice_b   = r_op_b[r_cnt*SLICE_W +: SLICE_W];
            w_slice_cin = r_carry;
        end
    end

    assign slice_a   = w_slice_a;
    assign slice_b   = w_slice_b;
    assign slice_cin = w_slice_cin;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

    // Result flags are decoded from registers; they are only meaningful
    // while out_valid=1 because r_res is rewritten slice by slice in RUN.
    assign out_s    = r_res;
    assign out_c48  = r_c_out;
    assign out_zero = (r_res == '0);
    assign out_ovf  = (r_op_a[W-1] == r_op_b[W-1]) && (r_res[W-1] != r_op_a[W-1]);

endmodule

// File: tb/tb_adder48_seq_ctrl.sv
`timescale 1ns/1ps
module tb_adder48_seq_ctrl;

    localparam int SLICE_W = 16;
    localparam int W       = 48;
    localparam int CLK_P   = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(CLK_P/2) clk = ~clk;

    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       in_a = '0;
    logic [W-1:0]       in_b = '0;
    logic               in_c0 = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_s;
    logic               out_c48;
    logic               out_zero;
    logic               out_ovf;
    logic               busy;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_cin;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic [1:0]         dbg_state;

    // shared external 16-bit adder slice
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, slice_cin};

    adder48_seq_ctrl #(.SLICE_W(SLICE_W), .NUM_SLICES(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c0(in_c0),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_c48(out_c48), .out_zero(out_zero), .out_ovf(out_ovf),
        .busy(busy),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_s(slice_s), .slice_cout(slice_cout),
        .dbg_state(dbg_state)
    );

    // scoreboard: {c48, sum[W-1:0], zero, ovf}
    logic [W+2:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0);
        logic [W:0] s;
        logic       z;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c0};
        z = (s[W-1:0] == '0);
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s, z, v};
    endfunction

    // driver: present operands and wait for accept; expected result pushed on accept
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0, output time t_acc);
        bit ok;
        int i;
        ok = 0;
        i = 0;
        t_acc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c0 = c0;
        while (!ok && i < 200) begin
            if (in_ready === 1'b1) ok = 1;
            else begin
                @(negedge clk);
                i++;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_accept: in_ready=%b after %0d cycles, required 1", in_ready, i);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(a, b, c0));
            @(posedge clk);
            t_acc = $time;
            #1;
            in_valid = 1'b0;
        end
    endtask

    // monitor: wait for out_valid, compare against queue head, then acknowledge
    task automatic sb_collect(output int waited);
        logic [W+2:0] e;
        bit seen;
        seen = 0;
        waited = 0;
        while (!seen && waited < 50) begin
            @(negedge clk);
            waited++;
            if (out_valid === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL result_timeout: out_valid=%b, required 1 within 50 cycles", out_valid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_unexpected: out_valid=1 with empty expected queue, out_s=%h", out_s);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (out_s !== e[W+1:2]) begin
                n_fail++;
                $display("FAIL result_sum: out_s=%h, required %h", out_s, e[W+1:2]);
            end
            n_tests++;
            if (out_c48 !== e[W+2]) begin
                n_fail++;
                $display("FAIL result_c48: out_c48=%b, required %b", out_c48, e[W+2]);
            end
            n_tests++;
            if ({out_zero, out_ovf} !== e[1:0]) begin
                n_fail++;
                $display("FAIL result_flags: zero,ovf=%b%b, required %b%b", out_zero, out_ovf, e[1], e[0]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_tests++;
        if (out_s !== '0) begin n_fail++; $display("FAIL reset_out_s: got %h, required 0", out_s); end
        n_tests++;
        if ({out_zero, out_c48, out_ovf} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: zero,c48,ovf=%b%b%b, required 100", out_zero, out_c48, out_ovf);
        end
        n_tests++;
        if ({slice_a, slice_b, slice_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_slice: a=%h b=%h cin=%b, required 0", slice_a, slice_b, slice_cin);
        end
    endtask

    task automatic test_cross_slice_carry();
        time t;
        int w;
        logic [2:0] exp_cin;
        logic [SLICE_W-1:0] exp_sa[3];
        exp_cin = 3'b010;   // cin for slice k is exp_cin[k]
        exp_sa[0] = 16'hFFFF;
        exp_sa[1] = 16'h0000;
        exp_sa[2] = 16'h0000;
        issue(48'h0000_0000_FFFF, 48'h0000_0000_0001, 1'b0, t);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (slice_cin !== exp_cin[k]) begin
                n_fail++;
                $display("FAIL cross_slice_cin%0d: got %b, required %b", k, slice_cin, exp_cin[k]);
            end
            n_tests++;
            if (slice_a !== exp_sa[k]) begin
                n_fail++;
                $display("FAIL cross_slice_a%0d: got %h, required %h", k, slice_a, exp_sa[k]);
            end
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cross_run%0d: out_valid=%b busy=%b, required 0 1", k, out_valid, busy);
            end
        end
        sb_collect(w);
        n_tests++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL cross_latency: out_valid after %0d more cycles, required 1 (3 edges after accept)", w);
        end
    endtask

    task automatic test_full_ripple();
        time t;
        int w;
        issue(48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, t);
        sb_collect(w);
    endtask

    task automatic test_signed_overflow();
        time t;
        int w;
        issue(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, t);
        sb_collect(w);
        issue(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, t);
        sb_collect(w);
    endtask

    task automatic test_backpressure();
        time t;
        int w;
        int i;
        logic [W-1:0] held_s;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        na = 48'h0F0F_0F0F_0F0F;
        nb = 48'h00F0_00F0_00F1;
        out_ready = 1'b0;
        issue(48'h1234_0000_FFFF, 48'h0000_FFFF_0001, 1'b1, t);
        i = 0;
        while (out_valid !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        // offer new operands while the result is stalled
        in_valid = 1'b1;
        in_a = na;
        in_b = nb;
        in_c0 = 1'b0;
        held_s = out_s;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_s !== held_s) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b out_s=%h, required 1 %h", k, out_valid, out_s, held_s);
            end
            n_tests++;
            if (in_ready !== 1'b0 || slice_a !== '0) begin
                n_fail++;
                $display("FAIL bp_no_accept%0d: in_ready=%b slice_a=%h, required 0 0000", k, in_ready, slice_a);
            end
            @(negedge clk);
        end
        sb_collect(w);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        exp_q.push_back(model(na, nb, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_next: busy=%b, required 1", busy);
        end
        sb_collect(w);
    endtask

    task automatic test_reset_mid_op();
        time t;
        int w;
        issue(48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333, 1'b0, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: busy=%b in_ready=%b out_valid=%b, required 0 1 0", busy, in_ready, out_valid);
        end
        n_tests++;
        if (out_s !== '0 || out_c48 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_out: out_s=%h c48=%b, required 0 0", out_s, out_c48);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: out_valid=%b, required 0", out_valid);
        end
        issue(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, t);
        sb_collect(w);
    endtask

    task automatic test_random();
        time t;
        int w;
        logic [63:0] ra;
        logic [63:0] rb;
        for (int k = 0; k < 8; k++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            issue(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sb_collect(w);
        end
    endtask

    task automatic test_back_to_back();
        time t_acc[4];
        logic [63:0] ra;
        logic [63:0] rb;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    issue(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), t_acc[k]);
                end
            end
            begin
                int w;
                for (int k = 0; k < 4; k++) sb_collect(w);
            end
        join
        for (int k = 1; k < 4; k++) begin
            n_tests++;
            if (t_acc[k] - t_acc[k-1] != 5 * CLK_P) begin
                n_fail++;
                $display("FAIL b2b_interval%0d: %0t, required %0d", k, t_acc[k] - t_acc[k-1], 5 * CLK_P);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cross_slice_carry();
        test_full_ripple();
        test_signed_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
